// File: rtl/seq_priority_encoder.sv
// rtl/seq_priority_encoder.sv - serialises a multi-hot request vector into binary indices
//
// Accepts an N-bit request vector over a valid/ready handshake, stores it, then
// emits the index of every set bit, one per output handshake, in priority order
// (lowest bit first when MSB_FIRST = 0, highest bit first when MSB_FIRST = 1).
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   request vector offered
//   in_ready   vector can be accepted (IDLE only)
//   in_vec     request vector, sampled on the input handshake
//   out_valid  out_idx holds a valid index
//   out_ready  consumer accepts the current index
//   out_idx    binary index of the current priority bit
//   out_last   current index is the final one of the vector
//   done       one-cycle pulse once the vector is fully serviced
//   count      popcount of the last accepted vector
//   onehot     last accepted vector had exactly one bit set
module seq_priority_encoder #(
  parameter int N = 8,
  parameter bit MSB_FIRST = 1'b0,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_vec,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic         out_last,
  output logic         done,
  output logic [W:0]   count,
  output logic         onehot
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic [N-1:0] pending;
  logic [N-1:0] pending_nxt;
  logic [N-1:0] pending_clr;
  logic [W:0]   vec_pop;
  logic [W-1:0] pri_idx;
  logic         single;
  logic         load;
  logic         done_nxt;

  // Popcount of the incoming vector; W+1 bits so that all-ones is representable.
  always_comb begin
    vec_pop = '0;
    for (int i = 0; i < N; i++) begin
      vec_pop = vec_pop + (W+1)'(in_vec[i]);
    end
  end

  // Priority index is taken from the stored vector only, so it stays stable
  // during a stall regardless of what the producer does with in_vec.
  // The loop direction is chosen so that the last match wins.
  always_comb begin
    pri_idx = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < N; i++) begin
        if (pending[i]) pri_idx = W'(i);
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (pending[i]) pri_idx = W'(i);
      end
    end
  end

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  assign single = (pending != '0) && ((pending & (pending - N'(1))) == '0);

  always_comb begin
    pending_clr          = pending;
    pending_clr[pri_idx] = 1'b0;
  end

  assign out_idx = pri_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    load        = 1'b0;
    done_nxt    = 1'b0;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_last    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          pending_nxt = in_vec;
          load        = 1'b1;
          // An empty vector has nothing to serve: report completion directly.
          if (in_vec == '0) begin
            done_nxt = 1'b1;
          end else begin
            state_nxt = SCAN;
          end
        end
      end
      SCAN: begin
        out_valid = 1'b1;
        out_last  = single;
        if (out_ready) begin
          pending_nxt = pending_clr;
          if (single) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      done    <= 1'b0;
      count   <= '0;
      onehot  <= 1'b0;
    end else begin
      pending <= pending_nxt;
      done    <= done_nxt;
      if (load) begin
        count  <= vec_pop;
        onehot <= (vec_pop == (W+1)'(1));
      end
    end
  end

endmodule

// File: tb/tb_seq_priority_encoder.sv
// tb/tb_seq_priority_encoder.sv - self-checking bench for seq_priority_encoder
//
// Three instances: k=0 N=8 LSB-first, k=1 N=8 MSB-first, k=2 N=4 LSB-first.
// The model keeps, per instance, the list of indices still to be served.
module tb_seq_priority_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] in_valid;
  logic [2:0] out_ready;
  logic [2:0] in_ready;
  logic [2:0] out_valid;
  logic [2:0] out_last;
  logic [2:0] done;
  logic [2:0] onehot;
  logic [7:0] vec0;
  logic [7:0] vec1;
  logic [3:0] vec2;
  logic [2:0] idx0;
  logic [2:0] idx1;
  logic [1:0] idx2;
  logic [3:0] cnt0;
  logic [3:0] cnt1;
  logic [2:0] cnt2;

  always #5 clk = ~clk;

  seq_priority_encoder #(.N(8), .MSB_FIRST(1'b0)) u_lsb8 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_vec(vec0), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_idx(idx0), .out_last(out_last[0]), .done(done[0]),
    .count(cnt0), .onehot(onehot[0])
  );

  seq_priority_encoder #(.N(8), .MSB_FIRST(1'b1)) u_msb8 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_vec(vec1), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_idx(idx1), .out_last(out_last[1]), .done(done[1]),
    .count(cnt1), .onehot(onehot[1])
  );

  seq_priority_encoder #(.N(4), .MSB_FIRST(1'b0)) u_lsb4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_vec(vec2), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_idx(idx2), .out_last(out_last[2]), .done(done[2]),
    .count(cnt2), .onehot(onehot[2])
  );

  int ml[3][8];
  int mh[3];
  int mn[3];
  int mcnt[3];
  int moh[3];
  int mdone[3];
  int last_idx[3];
  int cap[3][64];
  int capn[3];
  int checks = 0;
  int errors = 0;

  function automatic int nbits(int k);
    return (k == 2) ? 4 : 8;
  endfunction

  function automatic logic [7:0] vin(int k);
    case (k)
      0:       return vec0;
      1:       return vec1;
      default: return {4'b0, vec2};
    endcase
  endfunction

  function automatic int didx(int k);
    case (k)
      0:       return int'(idx0);
      1:       return int'(idx1);
      default: return int'(idx2);
    endcase
  endfunction

  function automatic int dcnt(int k);
    case (k)
      0:       return int'(cnt0);
      1:       return int'(cnt1);
      default: return int'(cnt2);
    endcase
  endfunction

  task automatic chk(input string name, input int k, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s[%0d] at %0t: got %0d expected %0d", name, k, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mh[k] = 0; mn[k] = 0; mcnt[k] = 0; moh[k] = 0; mdone[k] = 0;
    end
  endtask

  // Called at each rising edge with the inputs the bench is holding.
  task automatic model_update();
    for (int k = 0; k < 3; k++) begin
      logic [7:0] v;
      int d;
      d = 0;
      if (mh[k] >= mn[k]) begin
        if (in_valid[k]) begin
          v = vin(k);
          mh[k] = 0;
          mn[k] = 0;
          for (int s = 0; s < nbits(k); s++) begin
            int b;
            b = (k == 1) ? (nbits(k) - 1 - s) : s;
            if (v[b]) begin
              ml[k][mn[k]] = b;
              mn[k]++;
            end
          end
          mcnt[k] = mn[k];
          moh[k]  = (mn[k] == 1) ? 1 : 0;
          d       = (mn[k] == 0) ? 1 : 0;
        end
      end else if (out_ready[k]) begin
        if (capn[k] < 64) begin
          cap[k][capn[k]] = last_idx[k];
          capn[k]++;
        end
        mh[k]++;
        d = (mh[k] == mn[k]) ? 1 : 0;
      end
      mdone[k] = d;
    end
  endtask

  task automatic compare();
    for (int k = 0; k < 3; k++) begin
      int busy;
      busy = (mh[k] < mn[k]) ? 1 : 0;
      last_idx[k] = didx(k);
      chk("in_ready", k, int'(in_ready[k]), 1 - busy);
      chk("out_valid", k, int'(out_valid[k]), busy);
      chk("done", k, int'(done[k]), mdone[k]);
      chk("count", k, dcnt(k), mcnt[k]);
      chk("onehot", k, int'(onehot[k]), moh[k]);
      if (busy == 1) begin
        chk("out_idx", k, didx(k), ml[k][mh[k]]);
        chk("out_last", k, int'(out_last[k]), (mh[k] == mn[k] - 1) ? 1 : 0);
      end else begin
        chk("out_last", k, int'(out_last[k]), 0);
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) model_reset();
    else model_update();
    @(negedge clk);
    if (!rst) compare();
  endtask

  task automatic check_seq(input int k, input int base, input int n, input int e[8]);
    chk("beats", k, capn[k] - base, n);
    for (int i = 0; i < n; i++) begin
      if (base + i < 64) chk("beat_idx", k, cap[k][base + i], e[i]);
    end
  endtask

  initial begin
    int e[8];
    int b0;
    int b1;
    in_valid  = '0;
    out_ready = '0;
    vec0 = '0; vec1 = '0; vec2 = '0;
    for (int k = 0; k < 3; k++) begin
      capn[k] = 0;
      last_idx[k] = 0;
    end
    model_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst_in_ready", 0, int'(in_ready[0]), 1);
    chk("rst_out_valid", 0, int'(out_valid[0]), 0);
    chk("rst_done", 0, int'(done[0]), 0);
    chk("rst_count", 0, int'(cnt0), 0);
    cycle();
    cycle();
    rst = 1'b0;

    // Multi-hot 1010_0110 on both 8-bit instances, out_ready held high.
    b0 = capn[0]; b1 = capn[1];
    out_ready = 3'b111;
    in_valid[0] = 1'b1; in_valid[1] = 1'b1;
    vec0 = 8'b1010_0110; vec1 = 8'b1010_0110;
    cycle();
    in_valid = '0;
    chk("lit_count", 0, int'(cnt0), 4);
    chk("lit_onehot", 0, int'(onehot[0]), 0);
    chk("lit_first", 0, int'(idx0), 1);
    chk("lit_first", 1, int'(idx1), 7);
    repeat (6) cycle();
    e = '{1, 2, 5, 7, 0, 0, 0, 0};
    check_seq(0, b0, 4, e);
    e = '{7, 5, 2, 1, 0, 0, 0, 0};
    check_seq(1, b1, 4, e);

    // Only bit N-1 on LSB-first, all ones on MSB-first.
    b0 = capn[0]; b1 = capn[1];
    in_valid[0] = 1'b1; in_valid[1] = 1'b1;
    vec0 = 8'h80; vec1 = 8'hFF;
    cycle();
    in_valid = '0;
    chk("lit_last", 0, int'(out_last[0]), 1);
    repeat (10) cycle();
    e = '{7, 0, 0, 0, 0, 0, 0, 0};
    check_seq(0, b0, 1, e);
    e = '{7, 6, 5, 4, 3, 2, 1, 0};
    check_seq(1, b1, 8, e);

    // Legacy one-hot sweep on the 4-bit instance.
    for (int i = 0; i < 4; i++) begin
      b0 = capn[2];
      in_valid[2] = 1'b1;
      vec2 = 4'b0001 << i;
      cycle();
      in_valid[2] = 1'b0;
      cycle();
      chk("lit_sweep_done", 2, int'(done[2]), 1);
      chk("lit_sweep_onehot", 2, int'(onehot[2]), 1);
      cycle();
      e = '{i, 0, 0, 0, 0, 0, 0, 0};
      check_seq(2, b0, 1, e);
    end

    // Backpressure: out_ready toggles, in_vec churns during SCAN.
    b0 = capn[0];
    out_ready[0] = 1'b0;
    in_valid[0] = 1'b1;
    vec0 = 8'hFF;
    cycle();
    for (int c = 0; c < 16; c++) begin
      out_ready[0] = c[0];
      in_valid[0] = (c < 14);
      vec0 = 8'($urandom);
      cycle();
    end
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    repeat (3) cycle();
    chk("lit_bp_count", 0, int'(cnt0), 8);
    e = '{0, 1, 2, 3, 4, 5, 6, 7};
    check_seq(0, b0, 8, e);

    // Zero vector.
    in_valid[0] = 1'b1;
    vec0 = 8'h00;
    cycle();
    in_valid[0] = 1'b0;
    chk("lit_zero_done", 0, int'(done[0]), 1);
    chk("lit_zero_ready", 0, int'(in_ready[0]), 1);
    chk("lit_zero_count", 0, int'(cnt0), 0);
    cycle();
    chk("lit_zero_done_end", 0, int'(done[0]), 0);

    // Reset mid-SCAN after three beats of 8'hFF.
    b0 = capn[0];
    in_valid[0] = 1'b1;
    vec0 = 8'hFF;
    cycle();
    in_valid[0] = 1'b0;
    repeat (3) cycle();
    e = '{0, 1, 2, 0, 0, 0, 0, 0};
    check_seq(0, b0, 3, e);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", 0, int'(in_ready[0]), 1);
    chk("mid_rst_out_valid", 0, int'(out_valid[0]), 0);
    chk("mid_rst_out_idx", 0, int'(idx0), 0);
    chk("mid_rst_count", 0, int'(cnt0), 0);
    chk("mid_rst_onehot", 0, int'(onehot[0]), 0);
    chk("mid_rst_done", 0, int'(done[0]), 0);
    model_reset();
    cycle();
    rst = 1'b0;
    repeat (3) cycle();
    chk("post_rst_done", 0, int'(done[0]), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_priority_encoder.md
Name: seq_priority_encoder

Overview:
Parametrised, sequential successor to the team's 4-to-2 one-hot encoder. It accepts an N-bit request vector through a valid/ready handshake and stores it. It then emits the binary index of every set bit, one per output handshake, in priority order. Used wherever a multi-hot request word is serialised into indices, such as interrupt pending words and arbiter grant lists.

Parameters:
N, 8, request vector width; must be at least 2.
W, $clog2(N), index width; derived, not overridden.
MSB_FIRST, 0, 0 = lowest set bit served first; 1 = highest set bit served first.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  request vector offered.
in_ready  output  1  block can accept a vector; high only in IDLE.
in_vec  input  N  request vector, sampled on input handshake.
out_valid  output  1  out_idx holds a valid index.
out_ready  input  1  consumer accepts index.
out_idx  output  W  binary index of the current priority bit.
out_last  output  1  qualifies out_valid; current index is the final one of the vector.
done  output  1  one-cycle pulse; the vector is fully serviced.
count  output  W+1  popcount of the last accepted vector; held until the next accept.
onehot  output  1  last accepted vector had exactly one bit set; held until the next accept.

Behaviour:
- Reset (async assert, released on a clock edge):
  - state = IDLE, pending = 0.
  - count = 0, onehot = 0, done = 0.
  - in_ready = 1, out_valid = 0, out_idx = 0, out_last = 0.
- Reset mid-SCAN discards pending bits immediately; no done pulse.
- State IDLE:
  - in_ready = 1, out_valid = 0.
  - On in_valid & in_ready: pending <= in_vec; count <= popcount(in_vec); onehot <= (popcount == 1).
  - If in_vec == 0: stay in IDLE and pulse done on the next cycle. No output beats are produced.
  - Otherwise go to SCAN.
- State SCAN:
  - in_ready = 0, out_valid = 1.
  - out_idx = index of the priority bit of pending: lowest set bit if MSB_FIRST = 0, highest if 1. It is a combinational function of the pending register only, never of in_vec.
  - out_last = 1 when pending has exactly one bit set.
  - On out_valid & out_ready: clear that bit in pending. If out_last, go to IDLE and pulse done in the same cycle as the transition (done registered, high the cycle after the final handshake).
  - If out_ready is low, out_idx and out_last hold stable. The consumer may stall indefinitely.
- Throughput and latency:
  - One index per cycle while out_ready is held high.
  - First out_valid appears the cycle after the input handshake.
  - Minimum one IDLE cycle between vectors; in_ready is not asserted in the done cycle's predecessor.
- Widths: all index arithmetic is unsigned W bits. The count register is W+1 bits so that N set bits are representable (e.g. N=8 gives 8 = 4'b1000).
- Boundaries:
  - All N bits set: exactly N beats, in strict ascending order (descending if MSB_FIRST = 1).
  - Only bit N-1 set: single beat, out_idx = N-1, out_last = 1.
  - in_vec changing while in SCAN has no effect.
- Legacy equivalence: with N=4 and a one-hot input, the single beat's out_idx equals the old 4-to-2 code (0001→0, 0010→1, 0100→2, 1000→3) and onehot = 1.

Test Plan:
- Reset: assert rst mid-SCAN on vector 8'hFF after 3 beats -> immediately in_ready=1, out_valid=0, out_idx=0, count=0, onehot=0; no done pulse.
- One-hot sweep, N=4: accept 4'b0001, 4'b0010, 4'b0100, 4'b1000 in turn -> one beat each, out_idx = 0, 1, 2, 3, out_last=1, onehot=1, count=1, done one cycle after each beat.
- Multi-hot, LSB-first: accept 8'b1010_0110 with out_ready tied high -> out_idx 1, 2, 5, 7 on consecutive cycles; out_last only with 7; count=4, onehot=0.
- Multi-hot, MSB_FIRST=1: accept the same vector -> out_idx order 7, 5, 2, 1.
- Backpressure: accept 8'hFF, toggle out_ready 1/0 every cycle -> all 8 indices 0..7 in order; out_idx stable during stalls; count=8; in_vec changes during SCAN are ignored.
- Zero vector: accept 8'h00 -> no out_valid, done pulses the next cycle, count=0, onehot=0, in_ready stays 1.
